// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - opcodes, error codes and per-op depth requirements for the data stack
package stack_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_PUSH    = 4'd1;
  localparam logic [3:0] OP_DROP    = 4'd2;
  localparam logic [3:0] OP_DUP     = 4'd3;
  localparam logic [3:0] OP_SWAP    = 4'd4;
  localparam logic [3:0] OP_OVER    = 4'd5;
  localparam logic [3:0] OP_NIP     = 4'd6;
  localparam logic [3:0] OP_ROT     = 4'd7;
  localparam logic [3:0] OP_REPLACE = 4'd8;
  localparam logic [3:0] OP_BINOP   = 4'd9;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  // need = minimum depth; grow/shrink encode a depth delta of +1/-1
  typedef struct packed {
    logic [1:0] need;
    logic       grow;
    logic       shrink;
  } op_info_t;

  function automatic op_info_t op_info(input logic [3:0] op);
    op_info_t r;
    r = '0;
    case (op)
      OP_PUSH:    r.grow = 1'b1;
      OP_DROP:    begin r.need = 2'd1; r.shrink = 1'b1; end
      OP_DUP:     begin r.need = 2'd1; r.grow = 1'b1; end
      OP_SWAP:    r.need = 2'd2;
      OP_OVER:    begin r.need = 2'd2; r.grow = 1'b1; end
      OP_NIP:     begin r.need = 2'd2; r.shrink = 1'b1; end
      OP_ROT:     r.need = 2'd3;
      OP_REPLACE: r.need = 2'd1;
      OP_BINOP:   begin r.need = 2'd2; r.shrink = 1'b1; end
      default:    r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/stack_spill_ram.sv
// rtl/stack_spill_ram.sv - spill storage for cells below the three register cells
module stack_spill_ram #(
  parameter int WIDTH = 16,
  parameter int CELLS = 17,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_stack_unit.sv
// rtl/data_stack_unit.sv - Forth data stack: three register cells, spill RAM, depth and sticky error
module data_stack_unit
  import stack_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 20,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_tos,
  output logic [WIDTH-1:0] o_nos,
  output logic [WIDTH-1:0] o_3os,
  output logic [DW-1:0]    o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err,
  output logic [1:0]       o_err_code
);

  localparam int SPILL = DEPTH - 3;
  localparam int AW    = (SPILL > 1) ? $clog2(SPILL) : 1;

  logic [WIDTH-1:0] a, b, c;
  logic [DW-1:0]    depth;
  logic             err;
  logic [1:0]       err_code;

  op_info_t         info;
  logic             under, over, exec, refill, spill_we;
  logic [WIDTH-1:0] spill_rd;
  logic [DW-1:0]    waddr_full, raddr_full;

  assign info   = op_info(i_op);
  assign under  = depth < DW'(info.need);
  assign over   = info.grow && (depth == DW'(DEPTH));
  assign exec   = i_valid && !under && !over;
  // C only reloads when a real cell sits in the spill area
  assign refill = depth > DW'(3);

  assign spill_we   = exec && info.grow && (depth >= DW'(3));
  assign waddr_full = depth - DW'(3);
  assign raddr_full = depth - DW'(4);

  stack_spill_ram #(
    .WIDTH(WIDTH),
    .CELLS(SPILL),
    .AW   (AW)
  ) u_spill (
    .clk  (i_clk),
    .we   (spill_we),
    .waddr(waddr_full[AW-1:0]),
    .wdata(c),
    .raddr(raddr_full[AW-1:0]),
    .rdata(spill_rd)
  );

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      a        <= '0;
      b        <= '0;
      c        <= '0;
      depth    <= '0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      if (exec) begin
        case (i_op)
          OP_PUSH:    begin a <= i_data; b <= a; c <= b; end
          OP_DROP:    begin a <= b; b <= c; if (refill) c <= spill_rd; end
          OP_DUP:     begin b <= a; c <= b; end
          OP_SWAP:    begin a <= b; b <= a; end
          OP_OVER:    begin a <= b; b <= a; c <= b; end
          OP_NIP:     begin b <= c; if (refill) c <= spill_rd; end
          OP_ROT:     begin a <= c; b <= a; c <= b; end
          OP_REPLACE: a <= i_data;
          OP_BINOP:   begin a <= i_data; b <= c; if (refill) c <= spill_rd; end
          default:    ;
        endcase
        if (info.grow) begin
          depth <= depth + DW'(1);
        end else if (info.shrink) begin
          depth <= depth - DW'(1);
        end
      end

      if (i_clr_err) begin
        err      <= 1'b0;
        err_code <= ERR_NONE;
      end
      // a new error outranks a same-cycle clear; otherwise the first code is kept
      if (i_valid && (under || over)) begin
        err <= 1'b1;
        if (err_code == ERR_NONE || i_clr_err) begin
          err_code <= under ? ERR_UNDER : ERR_OVER;
        end
      end
    end
  end

  assign o_tos      = a;
  assign o_nos      = b;
  assign o_3os      = c;
  assign o_depth    = depth;
  assign o_empty    = (depth == '0);
  assign o_full     = (depth == DW'(DEPTH));
  assign o_err      = err;
  assign o_err_code = err_code;

endmodule

// File: tb/tb_data_stack_unit.sv
// tb/tb_data_stack_unit.sv - scoreboard bench for data_stack_unit
module tb_data_stack_unit;

  localparam int WIDTH = 16;
  localparam int DEPTH = 20;
  localparam int DW    = 5;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] data;
  logic             clr_err;
  logic [WIDTH-1:0] tos, nos, c3;
  logic [DW-1:0]    depth;
  logic             empty, full, err;
  logic [1:0]       err_code;

  always #5 clk = ~clk;

  data_stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_valid   (valid),
    .i_op      (op),
    .i_data    (data),
    .i_clr_err (clr_err),
    .o_tos     (tos),
    .o_nos     (nos),
    .o_3os     (c3),
    .o_depth   (depth),
    .o_empty   (empty),
    .o_full    (full),
    .o_err     (err),
    .o_err_code(err_code)
  );

  typedef struct {
    logic [15:0] tos;
    logic [15:0] nos;
    logic [15:0] c3;
    logic [4:0]  depth;
    logic        err;
    logic [1:0]  code;
    int          ncell;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %0h expected %0h", name, field, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "depth", 32'(depth), 32'(e.depth));
      chk(e.name, "err", 32'(err), 32'(e.err));
      chk(e.name, "err_code", 32'(err_code), 32'(e.code));
      chk(e.name, "empty", 32'(empty), 32'(e.depth == 5'd0));
      chk(e.name, "full", 32'(full), 32'(e.depth == 5'(DEPTH)));
      if (e.ncell >= 1) chk(e.name, "tos", 32'(tos), 32'(e.tos));
      if (e.ncell >= 2) chk(e.name, "nos", 32'(nos), 32'(e.nos));
      if (e.ncell >= 3) chk(e.name, "3os", 32'(c3), 32'(e.c3));
    end
  end

  function automatic int nc(input int d);
    return (d > 3) ? 3 : d;
  endfunction

  task automatic step(input logic rst, input logic [3:0] o, input logic [15:0] d,
                      input logic clr, input logic [15:0] et, input logic [15:0] en,
                      input logic [15:0] e3, input int ed, input logic ee,
                      input logic [1:0] ec, input string name);
    exp_t e;
    @(negedge clk);
    reset_n = !rst;
    valid   = 1'b1;
    op      = o;
    data    = d;
    clr_err = clr;
    e.tos = et; e.nos = en; e.c3 = e3; e.depth = 5'(ed);
    e.err = ee; e.code = ec; e.ncell = rst ? 3 : nc(ed); e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    reset_n = 1'b0; valid = 1'b0; op = 4'd0; data = '0; clr_err = 1'b0;

    step(1, 4'd1, 16'h5555, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "reset");
    step(0, 4'd1, 16'h0011, 0, 16'h0011, 16'h0, 16'h0, 1, 0, 2'd0, "push1");
    step(0, 4'd1, 16'h0022, 0, 16'h0022, 16'h0011, 16'h0, 2, 0, 2'd0, "push2");
    step(0, 4'd1, 16'h0033, 0, 16'h0033, 16'h0022, 16'h0011, 3, 0, 2'd0, "push3");

    step(1, 4'd0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "reset_fill");
    for (int i = 1; i <= 20; i++)
      step(0, 4'd1, 16'(i), 0, 16'(i), 16'(i - 1), 16'(i - 2), i, 0, 2'd0, "fill");
    step(0, 4'd1, 16'h00FF, 0, 16'd20, 16'd19, 16'd18, 20, 1, 2'd2, "overflow");
    for (int k = 1; k <= 20; k++)
      step(0, 4'd2, 16'hDEAD, 0, 16'(20 - k), 16'(19 - k), 16'(18 - k), 20 - k, 1, 2'd2, "drain");

    step(0, 4'd0, 16'h0, 1, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "clr_after_ovf");
    step(0, 4'd2, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 2'd1, "under_drop");
    step(0, 4'd0, 16'h0, 1, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "clr_err");
    step(0, 4'd1, 16'h0007, 0, 16'h0007, 16'h0, 16'h0, 1, 0, 2'd0, "push_one");
    step(0, 4'd4, 16'h0, 0, 16'h0007, 16'h0, 16'h0, 1, 1, 2'd1, "under_swap");
    step(0, 4'd0, 16'h0, 1, 16'h0007, 16'h0, 16'h0, 1, 0, 2'd0, "clr_again");
    step(0, 4'd4, 16'h0, 1, 16'h0007, 16'h0, 16'h0, 1, 1, 2'd1, "set_beats_clr");
    step(0, 4'd0, 16'h0, 0, 16'h0007, 16'h0, 16'h0, 1, 1, 2'd1, "sticky");

    step(1, 4'd0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "reset_rot");
    step(0, 4'd1, 16'd1, 0, 16'd1, 16'd0, 16'd0, 1, 0, 2'd0, "rot_push");
    step(0, 4'd1, 16'd2, 0, 16'd2, 16'd1, 16'd0, 2, 0, 2'd0, "rot_push");
    step(0, 4'd1, 16'd3, 0, 16'd3, 16'd2, 16'd1, 3, 0, 2'd0, "rot_push");
    step(0, 4'd7, 16'hAAAA, 0, 16'd1, 16'd3, 16'd2, 3, 0, 2'd0, "rot");
    step(0, 4'd5, 16'hAAAA, 0, 16'd3, 16'd1, 16'd3, 4, 0, 2'd0, "over");
    step(0, 4'd6, 16'hAAAA, 0, 16'd3, 16'd3, 16'd2, 3, 0, 2'd0, "nip");

    step(1, 4'd0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "reset_binop");
    step(0, 4'd1, 16'd5, 0, 16'd5, 16'd0, 16'd0, 1, 0, 2'd0, "bin_push");
    step(0, 4'd1, 16'd6, 0, 16'd6, 16'd5, 16'd0, 2, 0, 2'd0, "bin_push");
    step(0, 4'd1, 16'd7, 0, 16'd7, 16'd6, 16'd5, 3, 0, 2'd0, "bin_push");
    step(0, 4'd1, 16'd8, 0, 16'd8, 16'd7, 16'd6, 4, 0, 2'd0, "bin_push");
    step(0, 4'd9, 16'h000F, 0, 16'h000F, 16'd6, 16'd5, 3, 0, 2'd0, "binop");
    step(0, 4'd3, 16'hBEEF, 0, 16'h000F, 16'h000F, 16'd6, 4, 0, 2'd0, "dup");
    step(0, 4'd8, 16'h1234, 0, 16'h1234, 16'h000F, 16'd6, 4, 0, 2'd0, "replace");
    step(0, 4'd12, 16'hFFFF, 0, 16'h1234, 16'h000F, 16'd6, 4, 0, 2'd0, "op12_nop");
    step(0, 4'd2, 16'h0, 0, 16'h000F, 16'd6, 16'd5, 3, 0, 2'd0, "drop_refill");

    step(1, 4'd0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "reset_last");
    step(0, 4'd4, 16'h0, 0, 16'h0, 16'h0, 16'h0, 0, 1, 2'd1, "under_empty_swap");
    for (int i = 1; i <= 5; i++)
      step(0, 4'd1, 16'(i), 0, 16'(i), 16'(i - 1), 16'(i - 2), i, 1, 2'd1, "err_push");
    step(1, 4'd1, 16'h9999, 0, 16'h0, 16'h0, 16'h0, 0, 0, 2'd0, "reset_wins");

    @(negedge clk);
    valid   = 1'b0;
    reset_n = 1'b1;
    clr_err = 1'b0;
    for (int w = 0; w < 10 && sb.size() > 0; w++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain_scoreboard: got %0d pending expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_stack_unit.md
Name: data_stack_unit

Overview:
- Parametrised successor to the CPU's SmartStack: the Forth-style data stack feeding the ALU.
- Executes one stack operation per clock from a 4-bit opcode and exposes the top three cells (TOS, NOS, 3OS) combinationally from registers.
- Adds depth tracking, overflow/underflow detection with a sticky error, and the ops DUP/SWAP/OVER/NIP/ROT/REPLACE/BINOP.
- Sits between the instruction decoder (opcode, strobe) and the ALU (reads TOS/NOS, writes back result via BINOP).

Parameters:
- WIDTH, 16, cell width in bits.
- DEPTH, 20, maximum number of cells; minimum 4.
- DW, $clog2(DEPTH+1), depth counter width (derived, localparam).

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset_n  in  1  synchronous, active-low reset, sampled on rising edge of i_clk.
- i_valid  in  1  execute i_op this cycle.
- i_op  in  4  operation code (see Behaviour).
- i_data  in  WIDTH  operand for PUSH/REPLACE/BINOP.
- i_clr_err  in  1  clears sticky error.
- o_tos  out  WIDTH  top of stack (cell 0).
- o_nos  out  WIDTH  next on stack (cell 1).
- o_3os  out  WIDTH  third cell (cell 2).
- o_depth  out  DW  number of valid cells.
- o_empty  out  1  depth==0.
- o_full  out  1  depth==DEPTH.
- o_err  out  1  sticky error flag.
- o_err_code  out  2  01 underflow, 10 overflow, 00 none; holds first error.

Behaviour:
- Storage: cells 0..2 in registers A/B/C; cells 3..DEPTH-1 in an array spill[DEPTH-3] indexed by depth-4 (top of spill). Cell shift on push: spill[depth-3]<=C, C<=B, B<=A. Pop reverses; C reloads from spill[depth-4] when depth>3.
- Reset (i_reset_n==0 at edge): depth=0; A,B,C=0; o_err=0; o_err_code=00; spill contents don't-care. Reset wins over i_valid and i_clr_err.
- All ops single-cycle: result visible on outputs the cycle after the edge that sampled i_valid=1.
- Ops (need = minimum depth, delta = depth change):
  - 0 NOP, need 0, delta 0.
  - 1 PUSH, need 0, delta +1: A<=i_data.
  - 2 DROP, need 1, delta -1.
  - 3 DUP, need 1, delta +1: B<=A.
  - 4 SWAP, need 2, delta 0: A<->B.
  - 5 OVER, need 2, delta +1: A<=B, B<=A.
  - 6 NIP, need 2, delta -1: B<=C, C<=next spill.
  - 7 ROT, need 3, delta 0: (C B A) -> (B A C); A<=C, B<=A, C<=B.
  - 8 REPLACE, need 1, delta 0: A<=i_data.
  - 9 BINOP, need 2, delta -1: A<=i_data (ALU result), B<=C, C<=next spill.
  - 10-15: treated as NOP, no error.
- Underflow: depth<need -> no state change, o_err<=1; code 01 if code==00.
- Overflow: delta=+1 and depth==DEPTH -> no state change, error code 10 under the same rules.
- Sticky error: o_err/o_err_code hold until i_clr_err or reset. An error on the same cycle as i_clr_err is recorded (set wins).
- Cells beyond depth read as the last written value (not zeroed); the bench checks only cells below depth.
- i_data is ignored for ops other than PUSH, REPLACE, BINOP.

Decomposition:
- Package stack_pkg:
  - Opcode localparams OP_NOP..OP_BINOP.
  - ERR_NONE/ERR_UNDER/ERR_OVER codes.
  - Per-op need/delta lookup function.
- One sub-module, stack_spill_ram (DEPTH-3 x WIDTH, single write port, asynchronous read at a given index). This keeps the register-to-spill shift logic separate from storage.

Test Plan:
- Reset then PUSH 0x0011, 0x0022, 0x0033 -> tos=0x0033, nos=0x0022, 3os=0x0011, depth=3, err=0.
- Push 1..20 (DEPTH=20), then PUSH 0x00FF -> full=1, depth=20, tos=20, err=1, code=10; then 20 DROPs -> tos follows 19,18,...; empty=1 at end.
- From empty, DROP -> err=1, code=01, depth=0. Then i_clr_err -> err=0. Then SWAP at depth 1 -> code=01.
- Stack (1,2,3), 3 on top: ROT -> tos=1, nos=3, 3os=2. Then OVER -> tos=3, nos=1, depth=4. Then NIP -> tos=3, nos=3, 3os=2.
- Stack (5,6,7,8) with 8 on top: BINOP i_data=0x000F -> tos=0x000F, nos=6, 3os=5, depth=3 (spill refill verified).
- Assert i_reset_n=0 while i_valid=1 with PUSH at depth 5 and err set -> next cycle depth=0, err=0, tos=0.
